// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// byte + odd parity + stop out on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned BIT_TIMEOUT    = 100000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       ack_ok,
    output logic       err_noack,
    output logic       err_timeout
);
    localparam int unsigned MaxTo    = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int unsigned TimerMax = (MaxTo > INHIBIT_CYCLES) ? MaxTo : INHIBIT_CYCLES;
    localparam int unsigned TW       = $clog2(TimerMax + 1);
    localparam int unsigned FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [TW-1:0] InhibitLast = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] StartLast   = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] BitLast     = TW'(BIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StInhibit, StRts, StData, StWaitIdle, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    edge_q, edge_d;
    logic [9:0]    shift_q, shift_d;
    logic          drive_q, drive_d;
    logic          ack_q, ack_d, noack_q, noack_d, to_q, to_d;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_clk_q, filt_take, fall;
    logic [TW-1:0] timer_last;
    logic          timeout;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
        end
    end

    // A new clock level is taken only after FILTER_LEN consecutive differing samples.
    assign filt_take = (clk_s2 != filt_clk_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
    assign fall      = filt_take && !clk_s2;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_q <= '0;
            filt_clk_q <= 1'b1;
        end else if (clk_s2 == filt_clk_q) begin
            filt_cnt_q <= '0;
        end else if (filt_take) begin
            filt_cnt_q <= '0;
            filt_clk_q <= clk_s2;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    // Until the first device fall the long start timeout applies.
    assign timer_last = (edge_q == 4'd0) ? StartLast : BitLast;
    assign timeout    = (timer_q >= timer_last);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        edge_d      = edge_q;
        shift_d     = shift_q;
        drive_d     = drive_q;
        ack_d       = ack_q;
        noack_d     = noack_q;
        to_d        = to_q;
        tx_ready    = (state_q == StIdle);
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        ps2_clk_oe  = (state_q == StInhibit) || (state_q == StRts);
        ps2_dat_oe  = (state_q == StRts) ||
                      ((state_q == StData) && drive_q && !(timeout && !fall));

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    shift_d = {1'b1, ~^tx_data, tx_data};
                    timer_d = '0;
                    ack_d   = 1'b0;
                    noack_d = 1'b0;
                    to_d    = 1'b0;
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                if (timer_q >= InhibitLast) begin
                    state_d = StRts;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StRts: begin
                timer_d = '0;
                edge_d  = 4'd0;
                drive_d = 1'b1;
                state_d = StData;
            end
            StData: begin
                if (fall) begin
                    edge_d  = edge_q + 4'd1;
                    timer_d = TW'(1);
                    if (edge_q == 4'd10) begin
                        ack_d   = !dat_s2;
                        noack_d = dat_s2;
                        state_d = StWaitIdle;
                    end else begin
                        drive_d = ~shift_q[0];
                        shift_d = {1'b0, shift_q[9:1]};
                    end
                end else if (timeout) begin
                    to_d    = 1'b1;
                    drive_d = 1'b0;
                    state_d = StDone;
                end else if (timer_q != TW'(TimerMax)) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWaitIdle: begin
                if (filt_clk_q && dat_s2) begin
                    state_d = StDone;
                end else if (timeout) begin
                    to_d    = 1'b1;
                    ack_d   = 1'b0;
                    state_d = StDone;
                end else if (timer_q != TW'(TimerMax)) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            edge_q  <= '0;
            shift_q <= '0;
            drive_q <= 1'b0;
            ack_q   <= 1'b0;
            noack_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            edge_q  <= edge_d;
            shift_q <= shift_d;
            drive_q <= drive_d;
            ack_q   <= ack_d;
            noack_q <= noack_d;
            to_q    <= to_d;
        end
    end

    assign ack_ok      = ack_q;
    assign err_noack   = noack_q;
    assign err_timeout = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device BFM on wired-AND lines, table of transfers
// (fixed + random) checked against a frame/outcome model, plus reset and busy-request cases.
module tb_ps2_host_tx;
    localparam int unsigned INH      = 40;
    localparam int unsigned START_TO = 3000;
    localparam int unsigned BIT_TO   = 600;
    localparam int unsigned FLT      = 4;
    localparam int          HALF     = 20;

    logic       clk50 = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_ok, err_noack, err_timeout;
    logic       ps2_clk_in, ps2_dat_in;
    logic       bfm_clk = 1'b1;
    logic       bfm_dat = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    assign ps2_clk_in = bfm_clk & ~ps2_clk_oe;
    assign ps2_dat_in = bfm_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (START_TO),
        .BIT_TIMEOUT   (BIT_TO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .done       (done),
        .ack_ok     (ack_ok),
        .err_noack  (err_noack),
        .err_timeout(err_timeout)
    );

    always #10 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         do_ack;
        int         edges;
        bit         glitch;
        bit         exp_ack;
        bit         exp_noack;
        bit         exp_to;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit odd_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 0;
    endfunction

    // Device side: wait for request-to-send, clock out `edges` falls, sample on rising edges.
    task automatic bfm(input int edges, input bit do_ack, input bit glitch,
                       output logic [7:0] cap, output bit par, output bit stp,
                       output bit start_ok, output int f4);
        int guard = 0;
        cap = 8'h00; par = 1'b0; stp = 1'b0; start_ok = 1'b0; f4 = 0;
        while (ps2_clk_in !== 1'b0 && guard < 5000) begin
            @(negedge clk50);
            guard++;
        end
        while (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) && guard < 5000) begin
            @(negedge clk50);
            guard++;
        end
        if (guard >= 5000) begin
            check("bfm_rts_seen", 32'd0, 32'd1);
            return;
        end
        start_ok = 1'b1;
        repeat (HALF) @(negedge clk50);
        for (int e = 1; e <= edges; e++) begin
            if (e == 11 && do_ack) bfm_dat = 1'b0;
            bfm_clk = 1'b0;
            if (e == 4) f4 = cyc;
            repeat (HALF) @(negedge clk50);
            bfm_clk = 1'b1;
            if (e <= 8) cap[e-1] = ps2_dat_in;
            else if (e == 9) par = ps2_dat_in;
            else if (e == 10) stp = ps2_dat_in;
            repeat (HALF) @(negedge clk50);
        end
        bfm_dat = 1'b1;
        if (glitch) begin
            for (int g = 1; g <= 3; g++) begin
                repeat (50) @(negedge clk50);
                bfm_clk = 1'b0;
                repeat (g) @(negedge clk50);
                bfm_clk = 1'b1;
            end
        end
    endtask

    task automatic monitor(output int inh, output int rts, output int rel, output int dcyc,
                           output int clk_after, output bit got, output logic [2:0] fl,
                           output logic [1:0] oe_d);
        bit seen_clk = 1'b0;
        bit released = 1'b0;
        inh = 0; rts = 0; rel = 0; dcyc = 0; clk_after = 0; got = 1'b0; fl = 3'b0; oe_d = 2'b0;
        for (int i = 0; i < 20000; i++) begin
            if (ps2_clk_oe && !ps2_dat_oe) inh++;
            if (ps2_clk_oe && ps2_dat_oe) rts++;
            if (ps2_clk_oe) begin
                seen_clk = 1'b1;
                if (released) clk_after++;
            end else if (seen_clk && !released) begin
                released = 1'b1;
                rel = cyc;
            end
            if (done) begin
                got  = 1'b1;
                dcyc = cyc;
                fl   = {ack_ok, err_noack, err_timeout};
                oe_d = {ps2_clk_oe, ps2_dat_oe};
                break;
            end
            @(negedge clk50);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] cap;
        bit         par, stp, st_ok;
        int         f4, inh, rts, rel, dcyc, clk_after;
        bit         got;
        logic [2:0] fl;
        logic [1:0] oe_d;
        @(negedge clk50);
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(negedge clk50);
        tx_valid = 1'b0;
        check($sformatf("v%0d_flags_clr", idx), {29'd0, ack_ok, err_noack, err_timeout}, 32'd0);
        check($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        fork
            bfm(v.edges, v.do_ack, v.glitch, cap, par, stp, st_ok, f4);
            monitor(inh, rts, rel, dcyc, clk_after, got, fl, oe_d);
        join
        check($sformatf("v%0d_inhibit_len", idx), inh, INH);
        check($sformatf("v%0d_rts_len", idx), rts, 32'd1);
        check($sformatf("v%0d_clk_after_rel", idx), clk_after, 32'd0);
        check($sformatf("v%0d_done_seen", idx), {31'd0, got}, 32'd1);
        check($sformatf("v%0d_flags", idx), {29'd0, fl},
              {29'd0, v.exp_ack, v.exp_noack, v.exp_to});
        check($sformatf("v%0d_oe_at_done", idx), {30'd0, oe_d}, 32'd0);
        if (got) begin
            @(negedge clk50);
            check($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_ready_after", idx), {31'd0, tx_ready}, 32'd1);
            check($sformatf("v%0d_flags_hold", idx), {29'd0, ack_ok, err_noack, err_timeout},
                  {29'd0, fl});
        end
        if (v.edges == 11) begin
            check($sformatf("v%0d_start_bit", idx), {31'd0, st_ok}, 32'd1);
            check($sformatf("v%0d_byte", idx), {24'd0, cap}, {24'd0, v.data});
            check($sformatf("v%0d_parity", idx), {31'd0, par}, {31'd0, odd_parity(v.data)});
            check($sformatf("v%0d_stop", idx), {31'd0, stp}, 32'd1);
        end else if (v.edges == 0) begin
            check($sformatf("v%0d_start_to", idx), dcyc - rel, START_TO);
        end else begin
            // raw fall reaches the FSM after 2 sync stages plus the filter
            check_rng($sformatf("v%0d_bit_to", idx), dcyc - f4, BIT_TO, BIT_TO + FLT + 3);
        end
        repeat (5) @(negedge clk50);
    endtask

    initial begin
        logic [7:0] cap;
        bit         par, stp, st_ok, got, found;
        int         f4, inh, rts, rel, dcyc, clk_after, busy_cnt, done_cnt;
        logic [2:0] fl;
        logic [1:0] oe_d;

        vecs[0] = '{8'hFF, 1'b1, 11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hED, 1'b1, 11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 11, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hF4, 1'b1, 0,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 4,  1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 5; i < 11; i++) begin
            vecs[i].data      = 8'($urandom_range(0, 255));
            vecs[i].do_ack    = 1'($urandom_range(0, 1));
            vecs[i].edges     = 11;
            vecs[i].glitch    = 1'b0;
            vecs[i].exp_ack   = vecs[i].do_ack;
            vecs[i].exp_noack = !vecs[i].do_ack;
            vecs[i].exp_to    = 1'b0;
        end

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk50);
        check("rst_outputs", {24'd0, tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_ok,
              err_noack, err_timeout}, 32'h80);
        rst_n = 1'b1;
        repeat (3) @(negedge clk50);
        check("idle_outputs", {24'd0, tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_ok,
              err_noack, err_timeout}, 32'h80);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Requests while busy, and one held during the done cycle, must all be dropped.
        @(negedge clk50);
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk50);
        tx_valid = 1'b0;
        fork
            bfm(11, 1'b1, 1'b0, cap, par, stp, st_ok, f4);
            monitor(inh, rts, rel, dcyc, clk_after, got, fl, oe_d);
            begin
                for (int i = 0; i < 20000; i++) begin
                    @(negedge clk50);
                    tx_valid = 1'b0;
                    if (done) begin
                        tx_data = 8'h11; tx_valid = 1'b1;
                        @(negedge clk50);
                        tx_valid = 1'b0;
                        break;
                    end else if (busy && (i % 97 == 5)) begin
                        tx_data = 8'($urandom_range(0, 255)); tx_valid = 1'b1;
                    end
                end
            end
        join
        check("busyreq_byte", {24'd0, cap}, 32'hA5);
        check("busyreq_flags", {29'd0, fl}, 32'h4);
        busy_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk50);
            if (busy || ps2_clk_oe) busy_cnt++;
        end
        check("busyreq_no_second", busy_cnt, 32'd0);

        // Async reset during INHIBIT and during DATA.
        @(negedge clk50);
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk50);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk50);
        #2 rst_n = 1'b0;
        #1 check("rst_inhibit_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        @(negedge clk50);
        #2 rst_n = 1'b1;
        @(negedge clk50);
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk50);
        tx_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk50);
            if (!ps2_clk_oe && ps2_dat_oe) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reach_data", {31'd0, found}, 32'd1);
        repeat (30) @(negedge clk50);
        #2 rst_n = 1'b0;
        #1 check("rst_data_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        @(negedge clk50);
        #2 rst_n = 1'b1;
        @(negedge clk50);
        check("rst_ready", {30'd0, tx_ready, busy}, 32'h2);
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk50);
            if (done || busy) done_cnt++;
        end
        check("rst_no_done", done_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
